debounce_multi: RTL

- Parametrised N-channel successor to the scoreboard debouncer, clocked by the 100 Hz debounce clock.
- Synchronises raw button/switch inputs, filters them with a programmable stability count, and drives a debounced level per channel.
- Generates single-cycle press, release, long-press and auto-repeat pulses, so score buttons can repeat when held and the reset button can require a long hold.
- Sits between board I/O and the scoreboard control FSM.

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_chan.sv | 162 ++++++++++++++++
 rtl/debounce_multi.sv | 49 ++++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared types and default constants for the multi-channel debouncer.
//   hold_state_t : per-channel hold/repeat FSM states
//   DB_*         : default filter, hold and repeat timings (100 Hz clock)
//   cnt_width()  : counter width for a modulus, never below one bit
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } hold_state_t;

    localparam int unsigned DB_STABLE_CNT   = 3;
    localparam int unsigned DB_HOLD_TICKS   = 100;
    localparam int unsigned DB_REPEAT_TICKS = 20;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan
// One debounced channel: 2-flop synchroniser, stability filter, hold/repeat
// FSM and registered single-cycle event pulses.
//   clk_db     : debounce clock
//   rst        : synchronous active-high reset
//   din        : raw asynchronous input
//   level      : debounced level
//   press      : pulse on level 0->1
//   release_p  : pulse on level 1->0
//   long_press : pulse HOLD_TICKS cycles after press while still held
//   repeat_p   : pulse every REPEAT_TICKS after long_press (REPEAT_EN only)
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT   = DB_STABLE_CNT,
    parameter int unsigned HOLD_TICKS   = DB_HOLD_TICKS,
    parameter int unsigned REPEAT_TICKS = DB_REPEAT_TICKS,
    parameter bit          REPEAT_EN    = 1'b0
) (
    input  logic clk_db,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic press,
    output logic release_p,
    output logic long_press,
    output logic repeat_p
);

    localparam int unsigned SW = cnt_width(STABLE_CNT);
    // One extra count value (HOLD_TICKS) marks long_press as already issued
    // for non-repeating channels, so it cannot fire twice in one hold.
    localparam int unsigned HW = cnt_width(HOLD_TICKS + 1);
    localparam int unsigned RW = cnt_width(REPEAT_TICKS);

    localparam logic [SW-1:0] S_LAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] H_SAT  = HW'(HOLD_TICKS);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_TICKS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [SW-1:0] r_cnt;
    hold_state_t   r_state;
    logic [HW-1:0] r_hold;
    logic [RW-1:0] r_rpt;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          r_repeat;

    logic          w_level_nxt;
    logic [SW-1:0] w_cnt_nxt;
    logic          w_rise;
    logic          w_fall;
    hold_state_t   w_state_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic [RW-1:0] w_rpt_nxt;
    logic          w_long_nxt;
    logic          w_repeat_nxt;

    // Stability filter: any sample matching the current level restarts the count.
    always_comb begin
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        if (r_sync2 == r_level) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == S_LAST) begin
            w_level_nxt = r_sync2;
            w_cnt_nxt   = '0;
            w_rise      = r_sync2;
            w_fall      = ~r_sync2;
        end else begin
            w_cnt_nxt = r_cnt + SW'(1);
        end
    end

    // Hold/repeat FSM; a falling level pre-empts long_press and repeat_p.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_rpt_nxt    = r_rpt;
        w_long_nxt   = 1'b0;
        w_repeat_nxt = 1'b0;
        if (w_fall) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
            w_rpt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = HELD;
                        w_hold_nxt  = '0;
                    end
                end
                HELD: begin
                    if (r_hold == H_LAST) begin
                        w_long_nxt = 1'b1;
                        if (REPEAT_EN) begin
                            w_state_nxt = REPEAT;
                            w_rpt_nxt   = '0;
                        end else begin
                            w_hold_nxt = H_SAT;
                        end
                    end else if (r_hold != H_SAT) begin
                        w_hold_nxt = r_hold + HW'(1);
                    end
                end
                REPEAT: begin
                    if (r_rpt == R_LAST) begin
                        w_repeat_nxt = 1'b1;
                        w_rpt_nxt    = '0;
                    end else begin
                        w_rpt_nxt = r_rpt + RW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_db) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_cnt     <= '0;
            r_state   <= IDLE;
            r_hold    <= '0;
            r_rpt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_sync1   <= din;
            r_sync2   <= r_sync1;
            r_level   <= w_level_nxt;
            r_cnt     <= w_cnt_nxt;
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_rpt     <= w_rpt_nxt;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    assign level      = r_level;
    assign press      = r_press;
    assign release_p  = r_release;
    assign long_press = r_long;
    assign repeat_p   = r_repeat;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi
// N-channel button/switch debouncer between board I/O and the scoreboard
// control FSM. Each channel is an independent debounce_chan.
//   clk_db     : 100 Hz debounce clock
//   rst        : synchronous active-high reset
//   din        : raw asynchronous inputs
//   level      : debounced levels
//   press      : 1-cycle pulse per channel on level rise
//   release_p  : 1-cycle pulse per channel on level fall
//   long_press : 1-cycle pulse per channel after HOLD_TICKS of high level
//   repeat_p   : 1-cycle auto-repeat pulse on REPEAT_MASK channels
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned        N_CH         = 6,
    parameter int unsigned        STABLE_CNT   = DB_STABLE_CNT,
    parameter int unsigned        HOLD_TICKS   = DB_HOLD_TICKS,
    parameter int unsigned        REPEAT_TICKS = DB_REPEAT_TICKS,
    parameter logic [N_CH-1:0]    REPEAT_MASK  = 6'b001110
) (
    input  logic            clk_db,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_p
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_chan #(
            .STABLE_CNT  (STABLE_CNT),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .REPEAT_EN   (REPEAT_MASK[g])
        ) u_chan (
            .clk_db    (clk_db),
            .rst       (rst),
            .din       (din[g]),
            .level     (level[g]),
            .press     (press[g]),
            .release_p (release_p[g]),
            .long_press(long_press[g]),
            .repeat_p  (repeat_p[g])
        );
    end

endmodule
